// File: rtl/i2c_codec_reg_target.sv
// I2C write target modelling a codec control port: it decodes 7-bit register address + 9-bit data words into a shadow register file.
// Latency: bus inputs pass SYNC_STAGES flops, then one registered stage; rd_data has 1-cycle latency from rd_addr.
// Backpressure: none; the target never stretches SCL. It acks each byte by pulling SDA low through sda_oe.
// Optional feature: define I2C_CODEC_TGT_READ_EN to ack {DEV_ADDR,R} and return the last written word.
// Ports:
//   clk_clk, reset_reset (async active-high), scl_in, sda_in (pad inputs), sda_oe (1 = pull SDA low),
//   reg_wr_valid/reg_wr_addr/reg_wr_data (write pulse + held word), rd_addr/rd_data (shadow lookup),
//   busy (START..STOP), addr_err (sticky, out-of-range register write).
module i2c_codec_reg_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy,
  output logic       addr_err
);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ADDR   = 4'd1;
  localparam logic [3:0] ST_ACK_A  = 4'd2;
  localparam logic [3:0] ST_BYTE1  = 4'd3;
  localparam logic [3:0] ST_ACK1   = 4'd4;
  localparam logic [3:0] ST_BYTE2  = 4'd5;
  localparam logic [3:0] ST_ACK2   = 4'd6;
  localparam logic [3:0] ST_IGNORE = 4'd7;
`ifdef I2C_CODEC_TGT_READ_EN
  localparam logic [3:0] ST_RD     = 4'd8;
  localparam logic [3:0] ST_RD_ACK = 4'd9;
`endif

  // Synchronizers reset to the idle-bus level so reset release cannot fake an edge on SDA.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d;
  logic scl_s, sda_s;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic start_cond, stop_cond, scl_rise, scl_fall;
  // SCL must be high on both sides of the SDA transition to qualify as START/STOP.
  assign start_cond = scl_s && scl_d && sda_d && !sda_s;
  assign stop_cond  = scl_s && scl_d && !sda_d && sda_s;
  assign scl_rise   = scl_s && !scl_d;
  assign scl_fall   = !scl_s && scl_d;

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] byte1;
  logic       ack_arm;   // 0: waiting for the fall that starts the ack slot, 1: inside it
  logic [8:0] shadow [NUM_REGS];

  logic [7:0] rx_byte;
  logic [6:0] word_addr;
  logic [8:0] word_data;
  logic       word_in_range;

  assign rx_byte       = {shreg, sda_s};
  assign word_addr     = byte1[7:1];
  assign word_data     = {byte1[0], rx_byte};
  assign word_in_range = int'(word_addr) < NUM_REGS;

`ifdef I2C_CODEC_TGT_READ_EN
  logic       rd_mode;
  logic       tx_sel;      // 0: {addr, data[8]}, 1: data[7:0]
  logic       master_ack;
  logic [7:0] tx_hi, tx_lo, tx_byte;

  assign tx_hi   = {reg_wr_addr, reg_wr_data[8]};
  assign tx_lo   = reg_wr_data[7:0];
  assign tx_byte = tx_sel ? tx_lo : tx_hi;
`endif

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 7'd0;
      byte1        <= 8'd0;
      ack_arm      <= 1'b0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 7'd0;
      reg_wr_data  <= 9'd0;
      addr_err     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 9'd0;
`ifdef I2C_CODEC_TGT_READ_EN
      rd_mode      <= 1'b0;
      tx_sel       <= 1'b0;
      master_ack   <= 1'b0;
`endif
    end else begin
      reg_wr_valid <= 1'b0;
      if (start_cond) begin
        state   <= ST_ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_cond) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_arm <= 1'b0;
                if (state == ST_ADDR) begin
                  if (rx_byte == {DEV_ADDR, 1'b0}) begin
                    state <= ST_ACK_A;
`ifdef I2C_CODEC_TGT_READ_EN
                    rd_mode <= 1'b0;
                  end else if (rx_byte == {DEV_ADDR, 1'b1}) begin
                    state   <= ST_ACK_A;
                    rd_mode <= 1'b1;
`endif
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else if (state == ST_BYTE1) begin
                  byte1 <= rx_byte;
                  state <= ST_ACK1;
                end else begin
                  // Word commits as the second byte completes; a STOP before this point drops it.
                  state <= ST_ACK2;
                  if (word_in_range) begin
                    for (int i = 0; i < NUM_REGS; i++)
                      if (int'(word_addr) == i) shadow[i] <= word_data;
                    reg_wr_valid <= 1'b1;
                    reg_wr_addr  <= word_addr;
                    reg_wr_data  <= word_data;
                  end else begin
                    addr_err <= 1'b1;
                  end
                end
              end
            end
          end
          ST_ACK_A, ST_ACK1, ST_ACK2: begin
            if (scl_fall) begin
              if (!ack_arm) begin
                sda_oe  <= 1'b1;
                ack_arm <= 1'b1;
              end else begin
                ack_arm <= 1'b0;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                state   <= (state == ST_ACK1) ? ST_BYTE2 : ST_BYTE1;
`ifdef I2C_CODEC_TGT_READ_EN
                if (state == ST_ACK_A && rd_mode) begin
                  // First read bit goes out on the same fall that ends the address ack.
                  state  <= ST_RD;
                  tx_sel <= 1'b0;
                  sda_oe <= ~tx_hi[7];
                end
`endif
              end
            end
          end
`ifdef I2C_CODEC_TGT_READ_EN
          ST_RD: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state   <= ST_RD_ACK;
                ack_arm <= 1'b0;
              end
            end else if (scl_fall) begin
              // After k rising edges the next bit to present is index 7-k, i.e. ~bit_cnt.
              sda_oe <= ~tx_byte[~bit_cnt];
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              master_ack <= !sda_s;
            end else if (scl_fall) begin
              if (!ack_arm) begin
                sda_oe  <= 1'b0;
                ack_arm <= 1'b1;
              end else if (master_ack) begin
                ack_arm <= 1'b0;
                bit_cnt <= 3'd0;
                tx_sel  <= ~tx_sel;
                sda_oe  <= tx_sel ? ~tx_hi[7] : ~tx_lo[7];
                state   <= ST_RD;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_IGNORE;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  logic [8:0] rd_mux;
  always_comb begin
    rd_mux = 9'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(rd_addr) == i) rd_mux = shadow[i];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) rd_data <= 9'd0;
    else             rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_i2c_codec_reg_target.sv
// Directed bench for i2c_codec_reg_target: drives an I2C master on scl/sda and checks acks, write pulses,
// shadow readback, busy/addr_err and mid-transfer reset. SCL runs at 1/12 of the clock.
`timescale 1ns/1ps
module tb_i2c_codec_reg_target;

  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       reg_wr_valid;
  logic [6:0] reg_wr_addr;
  logic [8:0] reg_wr_data;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data;
  logic       busy;
  logic       addr_err;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_codec_reg_target dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .scl_in       (scl),
    .sda_in       (sda_bus),
    .sda_oe       (sda_oe),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;
  int oe_total = 0;

  always @(negedge clk) begin
    if (reg_wr_valid === 1'b1) pulse_total++;
    if (sda_oe === 1'b1) oe_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  // Ninth clock with SDA released; ack = target pulling low while SCL is high.
  task automatic get_ack(output logic ack);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #(Q/2);
    ack = ~sda_bus;
    #(Q/2);
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      scl = 1'b1; #(Q/2);
      b[i] = sda_bus;
      #(Q/2);
      scl = 1'b0; #Q;
    end
    send_bit(~master_ack);
    sda_m = 1'b1;
  endtask

  logic       a0, a1, a2, a3, a4;
  logic [7:0] rb0, rb1;
  int         p0, o0;

  initial begin
    #23;
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    chk("rst_valid", 32'(reg_wr_valid), 32'h0);
    chk("rst_addr", 32'(reg_wr_addr), 32'h0);
    chk("rst_data", 32'(reg_wr_data), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    rst = 1'b0;
    #40;

    // Single word: reg 4 <= 0x012
    p0 = pulse_total;
    i2c_start;
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h12, a2);
    chk("w1_acks", 32'({a0, a1, a2}), 32'h7);
    chk("w1_busy", 32'(busy), 32'h1);
    chk("w1_pulses", 32'(pulse_total - p0), 32'd1);
    chk("w1_addr", 32'(reg_wr_addr), 32'h04);
    chk("w1_data", 32'(reg_wr_data), 32'h012);
    i2c_stop;
    chk("w1_busy_stop", 32'(busy), 32'h0);
    rd_addr = 4'd4; #20;
    chk("w1_rd4", 32'(rd_data), 32'h012);

    // Two words in one transfer
    p0 = pulse_total;
    i2c_start;
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    chk("w2a_pulses", 32'(pulse_total - p0), 32'd1);
    chk("w2a_addr", 32'(reg_wr_addr), 32'h0F);
    chk("w2a_data", 32'(reg_wr_data), 32'h000);
    send_byte(8'h01, a3); send_byte(8'hFF, a4);
    chk("w2_acks", 32'({a0, a1, a2, a3, a4}), 32'h1F);
    chk("w2b_pulses", 32'(pulse_total - p0), 32'd2);
    chk("w2b_addr", 32'(reg_wr_addr), 32'h00);
    chk("w2b_data", 32'(reg_wr_data), 32'h1FF);
    i2c_stop;
    rd_addr = 4'd0; #20;
    chk("w2_rd0", 32'(rd_data), 32'h1FF);
    rd_addr = 4'd4; #20;
    chk("w2_rd4_kept", 32'(rd_data), 32'h012);

    // Foreign device address
    p0 = pulse_total; o0 = oe_total;
    i2c_start;
    send_byte(8'h36, a0); send_byte(8'h08, a1); send_byte(8'h12, a2);
    chk("ign_acks", 32'({a0, a1, a2}), 32'h0);
    chk("ign_oe_cycles", 32'(oe_total - o0), 32'd0);
    chk("ign_busy", 32'(busy), 32'h1);
    i2c_stop;
    chk("ign_busy_stop", 32'(busy), 32'h0);
    chk("ign_pulses", 32'(pulse_total - p0), 32'd0);

    // Partial word dropped by STOP, then a clean word
    p0 = pulse_total;
    i2c_start;
    send_byte(8'h34, a0); send_byte(8'h08, a1);
    i2c_stop;
    chk("part_pulses", 32'(pulse_total - p0), 32'd0);
    chk("part_busy", 32'(busy), 32'h0);
    i2c_start;
    send_byte(8'h34, a0); send_byte(8'h0A, a1); send_byte(8'h55, a2);
    i2c_stop;
    chk("part2_pulses", 32'(pulse_total - p0), 32'd1);
    chk("part2_addr", 32'(reg_wr_addr), 32'h05);
    chk("part2_data", 32'(reg_wr_data), 32'h055);

    // Out-of-range register 0x20
    p0 = pulse_total;
    i2c_start;
    send_byte(8'h34, a0); send_byte(8'h40, a1); send_byte(8'h01, a2);
    i2c_stop;
    chk("oor_acks", 32'({a0, a1, a2}), 32'h7);
    chk("oor_pulses", 32'(pulse_total - p0), 32'd0);
    chk("oor_addr_err", 32'(addr_err), 32'h1);
    chk("oor_addr_held", 32'(reg_wr_addr), 32'h05);

    // Reset in the middle of the address byte
    o0 = oe_total;
    i2c_start;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1; #20;
    chk("mid_sda_oe", 32'(sda_oe), 32'h0);
    chk("mid_valid", 32'(reg_wr_valid), 32'h0);
    chk("mid_addr", 32'(reg_wr_addr), 32'h0);
    chk("mid_data", 32'(reg_wr_data), 32'h0);
    chk("mid_rd_data", 32'(rd_data), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_addr_err", 32'(addr_err), 32'h0);
    rst = 1'b0; #20;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    get_ack(a0);
    send_byte(8'h08, a1);
    chk("post_rst_acks", 32'({a0, a1}), 32'h0);
    chk("post_rst_oe_cycles", 32'(oe_total - o0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    i2c_stop;

    // Write reg 4 then repeated START with the read address
    i2c_start;
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h12, a2);
    chk("rd_setup_acks", 32'({a0, a1, a2}), 32'h7);
    i2c_start;
    send_byte(8'h35, a3);
`ifdef I2C_CODEC_TGT_READ_EN
    chk("rd_addr_ack", 32'(a3), 32'h1);
    read_byte(1'b1, rb0);
    read_byte(1'b0, rb1);
    chk("rd_byte1", 32'(rb0), 32'h08);
    chk("rd_byte2", 32'(rb1), 32'h12);
`else
    chk("rd_addr_nack", 32'(a3), 32'h0);
    rb0 = 8'h00; rb1 = 8'h00;
`endif
    i2c_stop;
    chk("rd_end_busy", 32'(busy), 32'h0);
    chk("rd_end_oe", 32'(sda_oe), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
